// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: FSM encoding,
// fetch byte-enable constant and counter widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam logic [3:0] FULL_BE  = 4'hF;
  localparam int         TIMER_W  = 8;
  localparam int         STREAK_W = 4;

endpackage

// File: rtl/arb_timeout_timer.sv
// Grant-cycle counter with clear/enable and a terminal-count flag at
// TIMEOUT-1; the flag never fires when TIMEOUT is 0.
module arb_timeout_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMER_W-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
  localparam logic               TC_ON  = (TIMEOUT != 0);

  logic [TIMER_W-1:0] count;

  // Saturates so a disabled timeout cannot wrap during an endless grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tc = TC_ON && (count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch
// and data stages; data has priority, bounded by a fetch-starvation streak.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        me_req,
  input  logic        me_we,
  input  logic [3:0]  me_be,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  output logic        me_done,
  output logic [31:0] me_rdata,
  output logic        me_err,
  output logic        if_stall,
  output logic        me_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == '1) ? v : v + STREAK_W'(1);
  endfunction

  arb_state_e          state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                mem_req_nxt, mem_we_nxt;
  logic [3:0]          mem_be_nxt;
  logic [31:0]         mem_addr_nxt, mem_wdata_nxt;

  logic granted;
  logic tc;
  logic timeout_hit;
  logic xact_done;
  logic rd_ok;

  assign granted     = (state == GRANT_I) || (state == GRANT_D);
  assign timeout_hit = tc && !mem_ready;
  assign xact_done   = granted && (mem_ready || timeout_hit);

  arb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!granted || xact_done),
    .en  (granted),
    .tc  (tc)
  );

  // Completion is presented in the same cycle as mem_ready / timeout.
  assign rd_ok    = mem_ready && !mem_we;
  assign if_done  = (state == GRANT_I) && (mem_ready || timeout_hit);
  assign me_done  = (state == GRANT_D) && (mem_ready || timeout_hit);
  assign if_err   = if_done && timeout_hit;
  assign me_err   = me_done && timeout_hit;
  assign if_rdata = (if_done && rd_ok) ? mem_rdata : '0;
  assign me_rdata = (me_done && rd_ok) ? mem_rdata : '0;

  // Stalls are forced low while reset is held so the pipeline never
  // freezes on a transaction the reset has already thrown away.
  assign if_stall = rst && if_req && !if_done;
  assign me_stall = rst && me_req && !me_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_be    <= mem_be_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_be_nxt    = mem_be;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;

    case (state)
      IDLE: begin
        if (me_req && (!if_req || (streak < STREAK_MAX))) begin
          state_nxt     = GRANT_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = me_we;
          mem_be_nxt    = me_be;
          mem_addr_nxt  = me_addr;
          mem_wdata_nxt = me_wdata;
          // Only data grants that actually overtook a waiting fetch count.
          streak_nxt    = if_req ? sat_inc(streak) : '0;
        end else if (if_req) begin
          state_nxt    = GRANT_I;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_be_nxt   = FULL_BE;
          mem_addr_nxt = if_addr;
          streak_nxt   = '0;
        end else begin
          streak_nxt = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (xact_done) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for streak fairness and timeout boundaries.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        me_req = 1'b0;
  logic        me_we = 1'b0;
  logic [3:0]  me_be = '0;
  logic [31:0] me_addr = '0;
  logic [31:0] me_wdata = '0;
  logic        if_done, if_err, me_done, me_err, if_stall, me_stall;
  logic [31:0] if_rdata, me_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_DSTREAK (2),
    .TIMEOUT     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .me_req    (me_req),
    .me_we     (me_we),
    .me_be     (me_be),
    .me_addr   (me_addr),
    .me_wdata  (me_wdata),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .me_done   (me_done),
    .me_rdata  (me_rdata),
    .me_err    (me_err),
    .if_stall  (if_stall),
    .me_stall  (me_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        me_req;
    logic        me_we;
    logic [3:0]  me_be;
    logic [31:0] me_addr;
    logic [31:0] me_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [5:0]  x_ctl;       // {if_done,if_err,me_done,me_err,if_stall,me_stall}
    logic [31:0] x_if_rdata;
    logic [31:0] x_me_rdata;
    logic        x_mem_req;
    logic        chk_mem;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic mr, input logic mw, input logic [3:0] mb,
                     input logic [31:0] ma, input logic [31:0] md,
                     input logic rdy, input logic [31:0] rd, input logic [5:0] ctl,
                     input logic [31:0] xir, input logic [31:0] xmr, input logic xreq,
                     input logic chk, input logic xwe, input logic [3:0] xbe,
                     input logic [31:0] xaddr, input logic [31:0] xwd);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia;
    v.me_req = mr; v.me_we = mw; v.me_be = mb; v.me_addr = ma; v.me_wdata = md;
    v.mem_ready = rdy; v.mem_rdata = rd; v.x_ctl = ctl;
    v.x_if_rdata = xir; v.x_me_rdata = xmr; v.x_mem_req = xreq;
    v.chk_mem = chk; v.x_we = xwe; v.x_be = xbe; v.x_addr = xaddr; v.x_wdata = xwd;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[6];
    int grants;
    #1 rst = 1'b0;

    // reset state
    add(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    add(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    // fetch only, ready in grant cycle 3
    add(1, 1, 32'h00400000, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    add(1, 1, 32'h00400000, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'h0, 1, 1, 0, 4'hF, 32'h00400000, 32'h0);
    add(1, 1, 32'h00400000, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'h0, 1, 1, 0, 4'hF, 32'h00400000, 32'h0);
    add(1, 1, 32'h00400000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h24010001, 6'b100000, 32'h24010001, 32'h0, 1, 1, 0, 4'hF, 32'h00400000, 32'h0);
    add(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h00400000, 32'h0);
    // simultaneous: data first, fetch stalls through the following I grant
    add(1, 1, 32'h00400004, 1, 0, 4'hF, 32'h10010004, 32'h0, 0, 32'h0, 6'b000011, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    add(1, 1, 32'h00400004, 1, 0, 4'hF, 32'h10010004, 32'h0, 1, 32'hDEADBEEF, 6'b001010, 32'h0, 32'hDEADBEEF, 1, 1, 0, 4'hF, 32'h10010004, 32'h0);
    add(1, 1, 32'h00400004, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    add(1, 1, 32'h00400004, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h8C020000, 6'b100000, 32'h8C020000, 32'h0, 1, 1, 0, 4'hF, 32'h00400004, 32'h0);
    add(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    // store; fields change and req drops mid-grant without effect
    add(1, 0, 32'h0, 1, 1, 4'h3, 32'h10010008, 32'h0000ABCD, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    add(1, 0, 32'h0, 1, 1, 4'h3, 32'hFFFFFFF0, 32'h12345678, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 1, 1, 1, 4'h3, 32'h10010008, 32'h0000ABCD);
    add(1, 0, 32'h0, 0, 1, 4'h3, 32'hFFFFFFF0, 32'h12345678, 1, 32'h55555555, 6'b001000, 32'h0, 32'h0, 1, 1, 1, 4'h3, 32'h10010008, 32'h0000ABCD);
    add(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 1, 1, 4'h3, 32'h10010008, 32'h0000ABCD);
    // reset in the middle of a data grant
    add(1, 0, 32'h0, 1, 0, 4'hF, 32'h10010010, 32'h0, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    add(1, 0, 32'h0, 1, 0, 4'hF, 32'h10010010, 32'h0, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 1, 1, 0, 4'hF, 32'h10010010, 32'h0);
    add(0, 1, 32'h00400100, 1, 0, 4'hF, 32'h10010010, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    add(1, 1, 32'h00400100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    add(1, 1, 32'h00400100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h00000013, 6'b100000, 32'h00000013, 32'h0, 1, 1, 0, 4'hF, 32'h00400100, 32'h0);
    add(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

    foreach (vq[k]) begin
      @(negedge clk);
      rst = vq[k].rst; if_req = vq[k].if_req; if_addr = vq[k].if_addr;
      me_req = vq[k].me_req; me_we = vq[k].me_we; me_be = vq[k].me_be;
      me_addr = vq[k].me_addr; me_wdata = vq[k].me_wdata;
      mem_ready = vq[k].mem_ready; mem_rdata = vq[k].mem_rdata;
      #2;
      check($sformatf("v%0d ctl", k), 32'({if_done, if_err, me_done, me_err, if_stall, me_stall}), 32'(vq[k].x_ctl));
      check($sformatf("v%0d if_rdata", k), if_rdata, vq[k].x_if_rdata);
      check($sformatf("v%0d me_rdata", k), me_rdata, vq[k].x_me_rdata);
      check($sformatf("v%0d mem_req", k), 32'(mem_req), 32'(vq[k].x_mem_req));
      if (vq[k].chk_mem) begin
        check($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(vq[k].x_we));
        check($sformatf("v%0d mem_be", k), 32'(mem_be), 32'(vq[k].x_be));
        check($sformatf("v%0d mem_addr", k), mem_addr, vq[k].x_addr);
        check($sformatf("v%0d mem_wdata", k), mem_wdata, vq[k].x_wdata);
      end
    end

    // streak limit 2 with both requests held and a 1-cycle memory
    @(negedge clk);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h00400000;
    me_req = 1'b1; me_we = 1'b0; me_be = 4'hF; me_addr = 32'h10010000;
    mem_rdata = '0;
    grants = 0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = mem_req;
      #2;
      if (if_done || me_done) begin
        got[grants] = if_done ? 1 : 0;
        grants++;
      end
    end
    check("starve grant count", 32'(grants), 32'd6);
    for (int g = 0; g < 6; g++)
      check($sformatf("starve grant%0d is_fetch", g), 32'(got[g]), (g % 3 == 2) ? 32'd1 : 32'd0);
    @(negedge clk);
    if_req = 1'b0; me_req = 1'b0; mem_ready = 1'b0;

    // load that never sees mem_ready: timeout in grant cycle 16
    @(negedge clk);
    me_req = 1'b1; me_we = 1'b0; me_be = 4'hF; me_addr = 32'h10010020;
    mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
    #2;
    check("to arb me_stall", 32'(me_stall), 32'd1);
    for (int g = 1; g <= 16; g++) begin
      @(negedge clk);
      #2;
      if (g < 16) begin
        check($sformatf("to g%0d me_done", g), 32'(me_done), 32'd0);
      end else begin
        check("to g16 me_done", 32'(me_done), 32'd1);
        check("to g16 me_err", 32'(me_err), 32'd1);
        check("to g16 me_rdata", me_rdata, 32'h0);
        check("to g16 me_stall", 32'(me_stall), 32'd0);
      end
    end
    @(negedge clk);
    me_req = 1'b0;
    #2;
    check("to after mem_req", 32'(mem_req), 32'd0);
    check("to after me_done", 32'(me_done), 32'd0);

    // mem_ready on the last timer value wins over the timeout
    @(negedge clk);
    me_req = 1'b1; me_addr = 32'h10010024; mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int g = 1; g <= 16; g++) begin
      @(negedge clk);
      if (g == 16) begin
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      end
      #2;
      if (g == 16) begin
        check("race g16 me_done", 32'(me_done), 32'd1);
        check("race g16 me_err", 32'(me_err), 32'd0);
        check("race g16 me_rdata", me_rdata, 32'h0BADF00D);
      end
    end
    @(negedge clk);
    me_req = 1'b0; mem_ready = 1'b0;
    #2;
    check("race after mem_req", 32'(mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
